// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Cause logging is built only when RST_CAUSE_EN is defined.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    HOLD   = 2'd1,
    PERIPH = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_JTAG = 1;
  localparam int CAUSE_WDG  = 2;
  localparam int CAUSE_SW   = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_RST =
    CAUSE_W'(1 << CAUSE_POR);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-deassert reset synchronizer.
// Output rises SYNC_STAGES edges after rst_n releases.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: peripherals released first, core later.
// Define RST_CAUSE_EN to build the sticky reset-cause register.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES   = 16,
  parameter int CORE_DELAY_CYCLES = 4,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jtag_rst_req_i,
  input  logic       wdg_rst_req_i,
  input  logic       sw_rst_req_i,
  input  logic       rst_cause_clr_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic       rst_busy_o,
  output logic [3:0] rst_cause_o
);

  localparam int CNT_MAX =
    max2(RST_HOLD_CYCLES, CORE_DELAY_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST =
    CNT_W'((CORE_DELAY_CYCLES > 0) ?
           CORE_DELAY_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, periph_d;
  logic             core_q, core_d;
  logic             busy_q, busy_d;
  logic             sync_rel;
  logic             req;

  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sync_o(sync_rel)
  );

  assign req = jtag_rst_req_i
             | wdg_rst_req_i
             | sw_rst_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SYNC: begin
        if (sync_rel) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (CORE_DELAY_CYCLES == 0) ?
                    RUN : PERIPH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PERIPH: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Output flops follow the next state so releases land on the transition edge
  always_comb begin
    periph_d = (state_d == PERIPH) || (state_d == RUN);
    core_d   = (state_d == RUN);
    busy_d   = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
    end
  end

  assign periph_rst_n_o = periph_q;
  assign core_rst_n_o   = core_q;
  assign rst_busy_o     = busy_q;

`ifdef RST_CAUSE_EN
  logic [CAUSE_W-1:0] cause_q, cause_d;

  // A request on the clear cycle still sets its own bit
  always_comb begin
    cause_d = rst_cause_clr_i ? '0 : cause_q;
    if (jtag_rst_req_i) cause_d[CAUSE_JTAG] = 1'b1;
    if (wdg_rst_req_i)  cause_d[CAUSE_WDG]  = 1'b1;
    if (sw_rst_req_i)   cause_d[CAUSE_SW]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= CAUSE_RST;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;
`else
  logic unused_clr;
  assign unused_clr  = rst_cause_clr_i;
  assign rst_cause_o = '0;
`endif

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer clocked by the PLL output clock (clk0_out of the board PLL wrapper); sits directly downstream of the PLL.
- Turns the raw board reset and run-time reset requests (JTAG, watchdog, software) into staged, glitch-free resets.
- Peripherals are released first; the CPU core is released a fixed number of cycles later.
- Optionally records a sticky reset-cause register.

Parameters:
- RST_HOLD_CYCLES, 16, cycles both resets stay asserted after the synchronizer releases; legal range >=1.
- CORE_DELAY_CYCLES, 4, cycles between periph_rst_n_o release and core_rst_n_o release; 0 means both release on the same edge.
- SYNC_STAGES, 2, depth of the reset-deassert synchronizer; legal range >=2.

Ports:
- clk  in  1  PLL output clock, the single clock domain.
- rst_n  in  1  board reset; asynchronous, active-low.
- jtag_rst_req_i  in  1  debug-module reset request; level, synchronous to clk.
- wdg_rst_req_i  in  1  watchdog reset request; level, synchronous.
- sw_rst_req_i  in  1  software reset request from a CSR write; level, synchronous.
- rst_cause_clr_i  in  1  single-cycle clear of the cause register.
- periph_rst_n_o  out  1  peripheral/bus reset, active-low, registered.
- core_rst_n_o  out  1  CPU core reset, active-low, registered.
- rst_busy_o  out  1  high whenever the state is not RUN.
- rst_cause_o  out  4  sticky cause bits: [0] POR, [1] JTAG, [2] WDG, [3] SW.

Behaviour:
- The block uses one clock. Reset is asynchronous and active-low: rst_n low immediately forces periph_rst_n_o=0, core_rst_n_o=0, rst_busy_o=1, state=SYNC, counter=0, rst_cause_o=4'b0001.
- SYNC state:
  - Synchronizer chain shifts in 1 on each edge.
  - Taking edge 1 as the first rising edge with rst_n high, the chain output goes high after edge SYNC_STAGES; the next edge moves to HOLD with counter=0.
- HOLD state:
  - Counter increments each cycle.
  - When counter==RST_HOLD_CYCLES-1, move to PERIPH, or to RUN directly if CORE_DELAY_CYCLES==0.
  - periph_rst_n_o goes 1 on that transition edge.
- PERIPH state:
  - periph_rst_n_o=1, core_rst_n_o=0; counter counts CORE_DELAY_CYCLES.
  - At the terminal count, move to RUN and set core_rst_n_o=1 on that edge.
- RUN state: both outputs 1, rst_busy_o=0.
- Nominal timing (SYNC_STAGES=2):
  - periph release on edge 2+1+RST_HOLD_CYCLES = edge 19 with defaults.
  - core release on edge 19+CORE_DELAY_CYCLES = edge 23.
- Request handling:
  - Any request sampled high in HOLD, PERIPH or RUN: next edge drives both outputs to 0, counter=0, state=HOLD. Resets are always asserted synchronously, with no combinational path to the outputs.
  - A request held high keeps the block in HOLD with counter pinned at 0. The HOLD count starts on the first cycle with all requests low.
  - A request during SYNC does not alter sequencing; it is still logged in the cause register.
- Cause logging:
  - Each request sets its cause bit on any cycle it is sampled high. Simultaneous requests set all their bits.
  - rst_cause_clr_i clears all bits. A request on the same cycle wins for its own bit.
  - The POR bit is set only by rst_n.
- Counter width is $clog2(max(RST_HOLD_CYCLES,CORE_DELAY_CYCLES)+1); the counter never wraps.
- rst_n asserting mid-sequence aborts immediately to the reset values.
- All outputs come straight from flops.

Optional Feature:
- Macro RST_CAUSE_EN.
- Defined: rst_cause_o is implemented as specified above.
- Undefined:
  - No cause flops are built; rst_cause_o is tied to 4'b0000.
  - rst_cause_clr_i is ignored.
  - Sequencing is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum SYNC/HOLD/PERIPH/RUN, 2-bit encoding;
  - cause bit index constants CAUSE_POR=0, CAUSE_JTAG=1, CAUSE_WDG=2, CAUSE_SW=3;
  - cause width constant 4.
- One sub-module: rst_sync_chain, an async-assert/sync-deassert flop chain parameterized by SYNC_STAGES.

Test Plan:
- rst_n low 5 cycles then high, defaults -> periph_rst_n_o rises on edge 19, core_rst_n_o on edge 23, rst_busy_o falls with core, rst_cause_o=4'b0001.
- In RUN, 1-cycle wdg_rst_req_i -> both resets low the next edge, periph high 16 cycles later, core 4 cycles after that, rst_cause_o=4'b0101.
- jtag_rst_req_i held high for 30 cycles -> resets stay low throughout; periph releases 16 cycles after the request drops.
- sw_rst_req_i and rst_cause_clr_i on the same cycle -> rst_cause_o=4'b1000; a later lone clear -> 4'b0000.
- rst_n pulsed low while in PERIPH -> outputs low immediately, full sequence restarts from SYNC.
- CORE_DELAY_CYCLES=0 build -> periph and core release on the same edge (edge 19); RST_CAUSE_EN undefined -> rst_cause_o stays 0 in all scenarios above.
